// File: rtl/radio_tx_framer_if.sv
// Controller-side handshake between the node controller and the radio TX framer.
// The controller pushes payload bytes and watches busy/done/overflow status.
interface radio_tx_framer_if;
    logic       radio_send;
    logic [7:0] radio_data;
    logic       tx_last;
    logic       radio_busy;
    logic       tx_done;
    logic       overflow_err;

    modport master (
        output radio_send, radio_data, tx_last,
        input  radio_busy, tx_done, overflow_err
    );

    modport slave (
        input  radio_send, radio_data, tx_last,
        output radio_busy, tx_done, overflow_err
    );
endinterface

// File: rtl/radio_tx_framer.sv
// Buffers a payload, then sends SYNC, LEN, payload, CHECKSUM as back-to-back UART 8N1 bytes.
//   state   | meaning
//   COLLECT | idle / accepting payload bytes into the buffer
//   START   | driving the start bit (0) of the current byte
//   DATA    | driving the 8 data bits, LSB first
//   STOP    | driving the stop bit (1), then pick the next byte or finish
module radio_tx_framer #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         MAX_PAYLOAD  = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    radio_tx_framer_if.slave  ctl,
    output logic              tx_serial
);
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam int             IW        = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [BW-1:0]  BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]     MAX_CNT   = 8'(MAX_PAYLOAD);

    typedef enum logic [1:0] {COLLECT, START, DATA, STOP} state_t;
    typedef enum logic [1:0] {SYNC, LEN, PAY, CSUM} phase_t;

    state_t         state;
    phase_t         phase;
    logic [7:0]     pay_buf [MAX_PAYLOAD];
    logic [7:0]     count;
    logic [7:0]     checksum;
    logic [7:0]     pay_idx;
    logic [7:0]     tx_shift;
    logic [2:0]     bit_idx;
    logic [BW-1:0]  baud_cnt;
    logic           busy;
    logic           done;
    logic           ovf;

    logic           accept;
    logic           close_pkt;
    logic           baud_tc;
    logic [7:0]     count_nxt;

    assign accept    = enable && ctl.radio_send && !busy;
    assign count_nxt = count + 8'd1;
    assign close_pkt = ctl.tx_last || (count_nxt == MAX_CNT);
    assign baud_tc   = (baud_cnt == '0);

    assign ctl.radio_busy   = busy;
    assign ctl.tx_done      = done;
    assign ctl.overflow_err = ovf;

    // Payload storage carries no reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            pay_buf[count[IW-1:0]] <= ctl.radio_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            phase     <= SYNC;
            busy      <= 1'b0;
            tx_serial <= 1'b1;
            done      <= 1'b0;
            ovf       <= 1'b0;
            count     <= 8'd0;
            checksum  <= 8'd0;
            pay_idx   <= 8'd0;
            tx_shift  <= 8'd0;
            bit_idx   <= 3'd0;
            baud_cnt  <= '0;
        end else begin
            done <= 1'b0;
            ovf  <= 1'b0;
            if (!enable) begin
                state     <= COLLECT;
                phase     <= SYNC;
                busy      <= 1'b0;
                tx_serial <= 1'b1;
                count     <= 8'd0;
                checksum  <= 8'd0;
                baud_cnt  <= '0;
            end else begin
                ovf <= ctl.radio_send && busy;
                case (state)
                    COLLECT: begin
                        if (accept) begin
                            count    <= count_nxt;
                            checksum <= checksum + ctl.radio_data;
                            if (close_pkt) begin
                                busy      <= 1'b1;
                                state     <= START;
                                phase     <= SYNC;
                                tx_serial <= 1'b0;
                                tx_shift  <= SYNC_BYTE;
                                baud_cnt  <= BAUD_LOAD;
                            end
                        end
                    end
                    START: begin
                        if (baud_tc) begin
                            state     <= DATA;
                            tx_serial <= tx_shift[0];
                            tx_shift  <= {1'b0, tx_shift[7:1]};
                            bit_idx   <= 3'd0;
                            baud_cnt  <= BAUD_LOAD;
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (baud_tc) begin
                            baud_cnt <= BAUD_LOAD;
                            if (bit_idx == 3'd7) begin
                                state     <= STOP;
                                tx_serial <= 1'b1;
                            end else begin
                                bit_idx   <= bit_idx + 3'd1;
                                tx_serial <= tx_shift[0];
                                tx_shift  <= {1'b0, tx_shift[7:1]};
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    STOP: begin
                        if (baud_tc) begin
                            baud_cnt <= BAUD_LOAD;
                            // Every byte but the last starts its start bit right away: no idle gap.
                            if (phase == CSUM) begin
                                state    <= COLLECT;
                                phase    <= SYNC;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                count    <= 8'd0;
                                checksum <= 8'd0;
                            end else begin
                                state     <= START;
                                tx_serial <= 1'b0;
                            end
                            case (phase)
                                SYNC: begin
                                    phase    <= LEN;
                                    tx_shift <= count;
                                end
                                LEN: begin
                                    phase    <= PAY;
                                    tx_shift <= pay_buf[0];
                                    pay_idx  <= 8'd1;
                                end
                                PAY: begin
                                    if (pay_idx == count) begin
                                        phase    <= CSUM;
                                        tx_shift <= checksum + count;
                                    end else begin
                                        tx_shift <= pay_buf[pay_idx[IW-1:0]];
                                        pay_idx  <= pay_idx + 8'd1;
                                    end
                                end
                                CSUM: begin
                                    tx_shift <= 8'd0;
                                end
                            endcase
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_radio_tx_framer.sv
// Randomised and directed bench for radio_tx_framer against a frame-level model
// that expands each closed packet into the expected per-cycle serial waveform.
module tb_radio_tx_framer;
    localparam int         CPB  = 4;
    localparam int         MAXP = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic tx_serial;

    radio_tx_framer_if bus();

    radio_tx_framer #(
        .CLKS_PER_BIT (CPB),
        .MAX_PAYLOAD  (MAXP),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ctl       (bus),
        .tx_serial (tx_serial)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: packet bytes become a queue of expected line levels, one per cycle.
    logic [7:0] pkt[$];
    bit         mq[$];
    logic       m_busy = 1'b0;
    logic       m_ser  = 1'b1;
    logic       m_done = 1'b0;
    logic       m_ovf  = 1'b0;

    task automatic build_frame();
        logic [7:0] f[$];
        logic [7:0] s;
        logic [7:0] b;
        s = 8'(pkt.size());
        f.push_back(SYNC);
        f.push_back(s);
        foreach (pkt[i]) begin
            f.push_back(pkt[i]);
            s = s + pkt[i];
        end
        f.push_back(s);
        mq.delete();
        foreach (f[i]) begin
            b = f[i];
            repeat (CPB) mq.push_back(1'b0);
            for (int j = 0; j < 8; j++) repeat (CPB) mq.push_back(b[j]);
            repeat (CPB) mq.push_back(1'b1);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !enable) begin
            mq.delete();
            pkt.delete();
            m_busy = 1'b0;
            m_ser  = 1'b1;
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_ovf  = bus.radio_send && m_busy;
            m_done = 1'b0;
            if (m_busy) begin
                if (mq.size() > 0) begin
                    m_ser = mq.pop_front();
                end else begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_ser  = 1'b1;
                end
            end else if (bus.radio_send) begin
                pkt.push_back(bus.radio_data);
                if (bus.tx_last || pkt.size() == MAXP) begin
                    build_frame();
                    pkt.delete();
                    m_ser  = mq.pop_front();
                    m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("tx_serial", 16'(tx_serial), 16'(m_ser));
        chk("radio_busy", 16'(bus.radio_busy), 16'(m_busy));
        chk("tx_done", 16'(bus.tx_done), 16'(m_done));
        chk("overflow_err", 16'(bus.overflow_err), 16'(m_ovf));
    end

    // Busy run length and tx_done pulse count, used for literal frame-time pins.
    int busy_run = 0;
    int last_len = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else if (bus.radio_busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_len = busy_run;
            busy_run = 0;
        end
        if (bus.tx_done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        bus.radio_send = 1'b1;
        bus.radio_data = d;
        bus.tx_last    = last;
        @(negedge clk);
        bus.radio_send = 1'b0;
        bus.tx_last    = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int g;
        g = 0;
        while (bus.radio_busy && g < 4000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy still %0b after %0d cycles, required 0", nm, bus.radio_busy, g);
        end
    endtask

    logic [7:0] rx_q[$];
    task automatic rx_bytes(input int n);
        int         g;
        logic [7:0] v;
        g = 0;
        v = 8'd0;
        rx_q.delete();
        while (tx_serial !== 1'b0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_start_timeout: line %0b, required a start bit within 400 cycles", tx_serial);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            chk("rx_start_bit", 16'(tx_serial), 16'd0);
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(negedge clk);
                v[j] = tx_serial;
            end
            repeat (CPB) @(negedge clk);
            chk("rx_stop_bit", 16'(tx_serial), 16'd1);
            rx_q.push_back(v);
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [7:0] e[$]);
        for (int i = 0; i < e.size(); i++) begin
            if (i < rx_q.size()) chk(nm, 16'(rx_q[i]), 16'(e[i]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e[$];
        int d0;
        int g;
        int len;
        bit auto_close;
        bit dropped;
        int r;

        bus.radio_send = 1'b0;
        bus.radio_data = 8'd0;
        bus.tx_last    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_serial", 16'(tx_serial), 16'd1);
        chk("reset_busy", 16'(bus.radio_busy), 16'd0);
        chk("reset_done", 16'(bus.tx_done), 16'd0);
        chk("reset_ovf", 16'(bus.overflow_err), 16'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte packet
        d0 = done_cnt;
        send_byte(8'h3C, 1'b1);
        chk("t1_busy_next", 16'(bus.radio_busy), 16'd1);
        rx_bytes(4);
        e = '{8'hA5, 8'h01, 8'h3C, 8'h3D};
        chk_frame("t1_frame", e);
        wait_idle("t1_idle");
        @(negedge clk);
        chk("t1_busy_len", 16'(last_len), 16'd160);
        chk("t1_done_pulses", 16'(done_cnt - d0), 16'd1);

        // Checksum wrap-around
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h03, 1'b1);
        rx_bytes(6);
        e = '{8'hA5, 8'h03, 8'hFF, 8'hFF, 8'h03, 8'h04};
        chk_frame("t2_frame", e);
        wait_idle("t2_idle");
        @(negedge clk);
        chk("t2_busy_len", 16'(last_len), 16'd240);

        // Auto-close at MAX_PAYLOAD, then a dropped 17th strobe
        for (int i = 0; i < MAXP; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        chk("t3_autoclose_busy", 16'(bus.radio_busy), 16'd1);
        send_byte(8'hEE, 1'b0);
        chk("t3_overflow", 16'(bus.overflow_err), 16'd1);
        wait_idle("t3_idle");
        @(negedge clk);
        chk("t3_busy_len", 16'(last_len), 16'd760);

        // Overflow mid-frame, then strobe in the tx_done cycle
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        send_byte(8'h99, 1'b1);
        chk("t4_overflow", 16'(bus.overflow_err), 16'd1);
        g = 0;
        while (!bus.tx_done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("t4_done_seen", 16'(bus.tx_done), 16'd1);
        send_byte(8'h77, 1'b1);
        chk("t4_next_busy", 16'(bus.radio_busy), 16'd1);
        rx_bytes(4);
        e = '{8'hA5, 8'h01, 8'h77, 8'h78};
        chk_frame("t4_frame", e);
        wait_idle("t4_idle");

        // Enable dropped mid-payload; strobes while disabled are ignored
        d0 = done_cnt;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        bus.radio_send = 1'b1;
        bus.radio_data = 8'hC3;
        bus.tx_last    = 1'b1;
        @(negedge clk);
        chk("t5_abort_serial", 16'(tx_serial), 16'd1);
        chk("t5_abort_busy", 16'(bus.radio_busy), 16'd0);
        chk("t5_abort_ovf", 16'(bus.overflow_err), 16'd0);
        bus.radio_send = 1'b0;
        bus.tx_last    = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done", 16'(done_cnt - d0), 16'd0);
        send_byte(8'h42, 1'b1);
        rx_bytes(4);
        e = '{8'hA5, 8'h01, 8'h42, 8'h43};
        chk_frame("t5_frame", e);
        wait_idle("t5_idle");

        // Asynchronous reset mid-DATA
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b1);
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_serial", 16'(tx_serial), 16'd1);
        chk("t6_rst_busy", 16'(bus.radio_busy), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b1);
        rx_bytes(5);
        e = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        chk_frame("t6_frame", e);
        wait_idle("t6_idle");

        // Randomised packets, gaps, overflow strobes and occasional aborts
        for (int p = 0; p < 25; p++) begin
            len        = $urandom_range(1, MAXP);
            auto_close = (len == MAXP) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0) @(negedge clk);
                send_byte(8'($urandom_range(0, 255)), (i == len - 1) && !auto_close);
            end
            dropped = 1'b0;
            g = 0;
            while (bus.radio_busy && g < 3000) begin
                r = $urandom_range(0, 199);
                if (r < 3) begin
                    send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                end else if (r == 3 && (p % 5) == 0 && !dropped) begin
                    enable = 1'b0;
                    @(negedge clk);
                    enable = 1'b1;
                    dropped = 1'b1;
                end else begin
                    @(negedge clk);
                end
                g++;
            end
            if (g >= 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand_idle: busy still %0b after %0d cycles, required 0", bus.radio_busy, g);
            end
        end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
